// File: rtl/lif_multi_param_loader.sv
// Serial parameter loader for a multi-channel LIF neuron: shifts a framed bitstream into a shadow
// register and commits weights/leak/threshold/cycles atomically. Optional CRC-8 check: LIF_LOADER_CRC_EN.
module lif_multi_param_loader #(
    parameter int NUM_CH              = 4,
    parameter int W_WIDTH             = 3,
    parameter int LEAK_WIDTH          = 8,
    parameter int THR_WIDTH           = 8,
    parameter int CYC_WIDTH           = 4,
    parameter int DEFAULT_WA          = 2,
    parameter int DEFAULT_LEAK_RATE   = 2,
    parameter int DEFAULT_THRESHOLD   = 30,
    parameter int DEFAULT_LEAK_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        serial_data_in,
    input  logic                        load_enable,
    output logic [NUM_CH*W_WIDTH-1:0]   weights,
    output logic [LEAK_WIDTH-1:0]       leak_rate,
    output logic [THR_WIDTH-1:0]        threshold,
    output logic [CYC_WIDTH-1:0]        leak_cycles,
    output logic                        params_ready,
    output logic                        params_updated,
    output logic                        load_error
);

    localparam int P     = NUM_CH*W_WIDTH + LEAK_WIDTH + THR_WIDTH + CYC_WIDTH;
    localparam int SH_W  = P - 1;
    localparam int CNT_W = $clog2(P);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(P - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    // Holds the first P-1 payload bits; the final bit is taken straight from the input (or last_bit).
    logic [SH_W-1:0]  shadow;
    logic [P-1:0]     commit_frame;
    logic             do_commit;
    logic             do_abort;
    logic             crc_bad;

`ifdef LIF_LOADER_CRC_EN
    localparam logic [1:0]       ST_CRC_RX = 2'd2;
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(7);

    logic [7:0] crc_calc;
    logic [6:0] crc_rx;
    logic       last_bit;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    assign commit_frame = {shadow, last_bit};
`else
    assign commit_frame = {shadow, serial_data_in};
`endif

    always_comb begin
        do_commit = 1'b0;
        do_abort  = 1'b0;
        crc_bad   = 1'b0;
        if (enable) begin
            case (state)
                ST_SHIFT: begin
                    if (!load_enable) begin
                        do_abort = 1'b1;
                    end else if (cnt == LAST_BIT) begin
`ifndef LIF_LOADER_CRC_EN
                        do_commit = 1'b1;
`endif
                    end
                end
`ifdef LIF_LOADER_CRC_EN
                ST_CRC_RX: begin
                    if (!load_enable) begin
                        do_abort = 1'b1;
                    end else if (cnt == CRC_LAST) begin
                        if ({crc_rx, serial_data_in} == crc_calc) do_commit = 1'b1;
                        else                                      crc_bad   = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            shadow         <= '0;
            params_ready   <= 1'b1;
            params_updated <= 1'b0;
            load_error     <= 1'b0;
`ifdef LIF_LOADER_CRC_EN
            crc_calc       <= '0;
            crc_rx         <= '0;
            last_bit       <= 1'b0;
`endif
        end else begin
            params_updated <= do_commit;
            load_error     <= do_abort | crc_bad;
            if (do_commit || do_abort || crc_bad) params_ready <= 1'b1;
            if (enable) begin
                case (state)
                    ST_IDLE: begin
                        if (load_enable) begin
                            shadow       <= SH_W'(serial_data_in);
                            cnt          <= CNT_W'(1);
                            params_ready <= 1'b0;
                            state        <= ST_SHIFT;
`ifdef LIF_LOADER_CRC_EN
                            crc_calc     <= crc8_step(8'h00, serial_data_in);
`endif
                        end
                    end
                    ST_SHIFT: begin
                        if (do_abort) begin
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end else if (cnt == LAST_BIT) begin
                            cnt   <= '0;
`ifdef LIF_LOADER_CRC_EN
                            last_bit <= serial_data_in;
                            crc_calc <= crc8_step(crc_calc, serial_data_in);
                            state    <= ST_CRC_RX;
`else
                            state    <= ST_HOLD;
`endif
                        end else begin
                            shadow <= {shadow[SH_W-2:0], serial_data_in};
                            cnt    <= cnt + CNT_W'(1);
`ifdef LIF_LOADER_CRC_EN
                            crc_calc <= crc8_step(crc_calc, serial_data_in);
`endif
                        end
                    end
`ifdef LIF_LOADER_CRC_EN
                    ST_CRC_RX: begin
                        if (do_abort) begin
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end else if (cnt == CRC_LAST) begin
                            cnt   <= '0;
                            state <= ST_HOLD;
                        end else begin
                            crc_rx <= {crc_rx[5:0], serial_data_in};
                            cnt    <= cnt + CNT_W'(1);
                        end
                    end
`endif
                    default: begin
                        if (!load_enable) state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Active outputs move only at reset or on a commit edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            weights     <= {NUM_CH{W_WIDTH'(DEFAULT_WA)}};
            leak_rate   <= LEAK_WIDTH'(DEFAULT_LEAK_RATE);
            threshold   <= THR_WIDTH'(DEFAULT_THRESHOLD);
            leak_cycles <= CYC_WIDTH'(DEFAULT_LEAK_CYCLES);
        end else if (do_commit) begin
            for (int k = 0; k < NUM_CH; k++) begin
                weights[k*W_WIDTH +: W_WIDTH] <= commit_frame[P-1-k*W_WIDTH -: W_WIDTH];
            end
            leak_rate   <= commit_frame[CYC_WIDTH+THR_WIDTH +: LEAK_WIDTH];
            threshold   <= commit_frame[CYC_WIDTH +: THR_WIDTH];
            leak_cycles <= commit_frame[CYC_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_lif_multi_param_loader.sv
// Scoreboard bench for lif_multi_param_loader: stimulus pushes expected commit/error events,
// a negedge monitor pops and compares them whenever a pulse output fires.
module tb_lif_multi_param_loader;

    typedef struct packed {
        logic        err;
        logic [11:0] w;
        logic [7:0]  lr;
        logic [7:0]  th;
        logic [3:0]  cy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        serial_data_in;
    logic        load_enable;
    logic [11:0] weights;
    logic [7:0]  leak_rate;
    logic [7:0]  threshold;
    logic [3:0]  leak_cycles;
    logic        params_ready;
    logic        params_updated;
    logic        load_error;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t cur;

    localparam exp_t DEFAULTS = '{err: 1'b0, w: 12'h492, lr: 8'd2, th: 8'd30, cy: 4'd2};
    // Frame A: weights 1,2,3,4; leak 0x05; thr 0x40; cyc 0x3 -> weights bus 0x8D1
    localparam logic [31:0] FRAME_A = {3'd1, 3'd2, 3'd3, 3'd4, 8'h05, 8'h40, 4'h3};
    // Frame B: weights 7,0,5,6 -> 0x007 | 0x000 | 0x140 | 0xC00 = 0xD47
    localparam logic [31:0] FRAME_B = {3'd7, 3'd0, 3'd5, 3'd6, 8'hA5, 8'hFF, 4'hF};

    lif_multi_param_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .serial_data_in (serial_data_in),
        .load_enable    (load_enable),
        .weights        (weights),
        .leak_rate      (leak_rate),
        .threshold      (threshold),
        .leak_cycles    (leak_cycles),
        .params_ready   (params_ready),
        .params_updated (params_updated),
        .load_error     (load_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input exp_t e);
        chk({tag, "_weights"},     {20'd0, weights},     {20'd0, e.w});
        chk({tag, "_leak_rate"},   {24'd0, leak_rate},   {24'd0, e.lr});
        chk({tag, "_threshold"},   {24'd0, threshold},   {24'd0, e.th});
        chk({tag, "_leak_cycles"}, {28'd0, leak_cycles}, {28'd0, e.cy});
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (params_updated === 1'b1 || load_error === 1'b1)) begin
            chk("pulse_exclusive", {31'd0, params_updated & load_error}, 32'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got upd=%0b err=%0b expected no pulse",
                         params_updated, load_error);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_kind", {31'd0, load_error}, {31'd0, e.err});
                chk("pulse_ready", {31'd0, params_ready}, 32'd1);
                chk_outputs("mon", e);
            end
        end
    end

`ifdef LIF_LOADER_CRC_EN
    function automatic logic [7:0] crc8(input logic [31:0] f);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 31; i >= 0; i--) begin
            fb = c[7] ^ f[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction
`endif

    task automatic send_bits(input logic [31:0] f, input int nbits, input int stall_at,
                             input logic [7:0] crc_xor);
        logic bits[$];
        for (int i = 31; i >= 0; i--) bits.push_back(f[i]);
`ifdef LIF_LOADER_CRC_EN
        begin
            logic [7:0] c;
            c = crc8(f) ^ crc_xor;
            for (int i = 7; i >= 0; i--) bits.push_back(c[i]);
        end
`else
        if (crc_xor != 8'h00) $display("note: crc_xor ignored without CRC");
`endif
        for (int i = 0; i < nbits; i++) begin
            if (i == stall_at) begin
                enable = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    serial_data_in = ~serial_data_in;
                    @(posedge clk); #1;
                end
                enable = 1'b1;
            end
            load_enable    = 1'b1;
            serial_data_in = bits[i];
            @(posedge clk); #1;
        end
    endtask

    task automatic full_len(output int n);
`ifdef LIF_LOADER_CRC_EN
        n = 40;
`else
        n = 32;
`endif
    endtask

    task automatic end_frame();
        load_enable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic commit_frame(input string tag, input logic [31:0] f, input exp_t e,
                                input int stall_at);
        int n;
        full_len(n);
        cur = e;
        sb.push_back(e);
        send_bits(f, n, stall_at, 8'h00);
        chk({tag, "_upd_latency"}, {31'd0, params_updated}, 32'd1);
        end_frame();
        chk({tag, "_ready_after"}, {31'd0, params_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; load_enable = 1'b0; serial_data_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_outputs("reset", DEFAULTS);
        chk("reset_ready", {31'd0, params_ready}, 32'd1);
        chk("reset_updated", {31'd0, params_updated}, 32'd0);
        chk("reset_error", {31'd0, load_error}, 32'd0);
        cur = DEFAULTS;

        commit_frame("frameA", FRAME_A, '{1'b0, 12'h8D1, 8'h05, 8'h40, 4'h3}, -1);
        commit_frame("frameB", FRAME_B, '{1'b0, 12'hD47, 8'hA5, 8'hFF, 4'hF}, -1);

        // Abort after 10 bits: error pulse, outputs keep frame B.
        sb.push_back('{1'b1, cur.w, cur.lr, cur.th, cur.cy});
        send_bits(FRAME_A, 10, -1, 8'h00);
        chk("abort_ready_mid", {31'd0, params_ready}, 32'd0);
        end_frame();
        chk("abort_error_pulse", {31'd0, load_error}, 32'd1);
        chk("abort_ready", {31'd0, params_ready}, 32'd1);
        chk_outputs("abort_hold", cur);

        commit_frame("stallA", FRAME_A, '{1'b0, 12'h8D1, 8'h05, 8'h40, 4'h3}, 12);
        commit_frame("zeros", 32'h0, '{1'b0, 12'h000, 8'h00, 8'h00, 4'h0}, -1);
        commit_frame("ones", 32'hFFFF_FFFF, '{1'b0, 12'hFFF, 8'hFF, 8'hFF, 4'hF}, -1);

`ifdef LIF_LOADER_CRC_EN
        // Corrupted CRC: error pulse, no commit, bits ignored in HOLD.
        sb.push_back('{1'b1, cur.w, cur.lr, cur.th, cur.cy});
        send_bits(FRAME_B, 40, -1, 8'h01);
        chk("crc_bad_error", {31'd0, load_error}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            serial_data_in = i[0];
            @(posedge clk); #1;
        end
        end_frame();
        chk("crc_bad_ready", {31'd0, params_ready}, 32'd1);
        chk_outputs("crc_bad_hold", cur);
        commit_frame("crc_good", FRAME_B, '{1'b0, 12'hD47, 8'hA5, 8'hFF, 4'hF}, -1);
`endif

        // Reset mid-frame at bit 20: defaults, no pulses, clean restart.
        send_bits(FRAME_B, 20, -1, 8'h00);
        load_enable = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_outputs("midreset", DEFAULTS);
        chk("midreset_ready", {31'd0, params_ready}, 32'd1);
        chk("midreset_pulses", {30'd0, params_updated, load_error}, 32'd0);
        cur = DEFAULTS;
        commit_frame("restartA", FRAME_A, '{1'b0, 12'h8D1, 8'h05, 8'h40, 4'h3}, -1);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
